dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 138 +++++++++++++
 tb/tb_dmem_responder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder for the CPU MEM stage (IDLE -> WAIT -> RESP).
// Wait states before each response exist only when DMEM_WAIT_EN is defined.
module dmem_responder #(
  parameter int NWORDS = 128,
  parameter int WAIT   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [6:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

`ifdef DMEM_WAIT_EN
  localparam int WAIT_CYC = WAIT;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;
  logic [3:0] cnt_q, cnt_d;
`else
  // Without wait states the response always follows accept by one cycle.
  localparam int WAIT_CYC = 0 * WAIT;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RESP = 2'd2} state_t;
`endif

  state_t      state_q, state_d;
  logic        ready_en_q;
  logic        we_q;
  logic [6:0]  addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [31:0] mem [NWORDS];

  logic        accept, go_resp, in_range;
  logic        acc_we;
  logic [6:0]  acc_addr;
  logic [31:0] acc_wdata;
  logic [AW-1:0] idx;

  assign req_ready = ready_en_q && (state_q == S_IDLE);
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // Entering RESP straight from IDLE uses the live request; from WAIT it uses the captured one.
  assign acc_we    = (state_q == S_IDLE) ? req_we    : we_q;
  assign acc_addr  = (state_q == S_IDLE) ? req_addr  : addr_q;
  assign acc_wdata = (state_q == S_IDLE) ? req_wdata : wdata_q;
  assign in_range  = ({1'b0, acc_addr} < 8'(NWORDS));
  assign idx       = acc_addr[AW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
`ifdef DMEM_WAIT_EN
      cnt_q   <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
`ifdef DMEM_WAIT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    go_resp = 1'b0;
`ifdef DMEM_WAIT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (WAIT_CYC > 0) begin
`ifdef DMEM_WAIT_EN
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_CYC - 1);
`endif
          end else begin
            state_d = S_RESP;
            go_resp = 1'b1;
          end
        end
      end
`ifdef DMEM_WAIT_EN
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
          go_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
`endif
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (go_resp) begin
        rdata_q <= (!acc_we && in_range) ? mem[idx] : 32'd0;
        err_q   <= !in_range;
      end
    end
  end

  // Memory is not reset; a write only lands on the edge that enters RESP.
  always_ff @(posedge clk) begin
    if (go_resp && acc_we && in_range) mem[idx] <= acc_wdata;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (NWORDS/WAIT = 64/2, 128/0, 128/5) against a cycle-count model.
module tb_dmem_responder;

`ifdef DMEM_WAIT_EN
  localparam bit WEN = 1'b1;
`else
  localparam bit WEN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  initial forever #5 clk = ~clk;

  logic        rq_v [3];
  logic        rq_we [3];
  logic [6:0]  rq_a [3];
  logic [31:0] rq_d [3];
  logic        rs_r [3];
  logic        req_ready_o [3];
  logic        rsp_valid_o [3];
  logic [31:0] rsp_rdata_o [3];
  logic        rsp_err_o [3];

  dmem_responder #(.NWORDS(64), .WAIT(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(rq_v[0]), .req_ready(req_ready_o[0]),
    .req_we(rq_we[0]), .req_addr(rq_a[0]), .req_wdata(rq_d[0]), .rsp_valid(rsp_valid_o[0]),
    .rsp_ready(rs_r[0]), .rsp_rdata(rsp_rdata_o[0]), .rsp_err(rsp_err_o[0]));
  dmem_responder #(.NWORDS(128), .WAIT(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(rq_v[1]), .req_ready(req_ready_o[1]),
    .req_we(rq_we[1]), .req_addr(rq_a[1]), .req_wdata(rq_d[1]), .rsp_valid(rsp_valid_o[1]),
    .rsp_ready(rs_r[1]), .rsp_rdata(rsp_rdata_o[1]), .rsp_err(rsp_err_o[1]));
  dmem_responder #(.NWORDS(128), .WAIT(5)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(rq_v[2]), .req_ready(req_ready_o[2]),
    .req_we(rq_we[2]), .req_addr(rq_a[2]), .req_wdata(rq_d[2]), .rsp_valid(rsp_valid_o[2]),
    .rsp_ready(rs_r[2]), .rsp_rdata(rsp_rdata_o[2]), .rsp_err(rsp_err_o[2]));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int nw_of(input int i);
    return (i == 0) ? 64 : 128;
  endfunction

  // Wait-state cycles between accept and response for each instance.
  function automatic int lat_of(input int i);
    if (!WEN) return 0;
    return (i == 0) ? 2 : ((i == 1) ? 0 : 5);
  endfunction

  // Model: busy/resp flags, cycles left in WAIT, pending request, last response, and memory image.
  bit          busy [3];
  bit          resp [3];
  bit          rok [3];
  int          wl [3];
  bit          p_we [3];
  logic [6:0]  p_a [3];
  logic [31:0] p_d [3];
  logic [31:0] res_d [3];
  bit          res_e [3];
  bit          res_k [3];
  logic [31:0] mm [3][128];
  bit          mk [3][128];

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      busy[i] = 1'b0; resp[i] = 1'b0; rok[i] = 1'b0; wl[i] = 0;
      res_d[i] = 32'd0; res_e[i] = 1'b0; res_k[i] = 1'b1;
    end
  endtask

  function automatic void finish_req(input int i);
    bit inr;
    inr = (int'(p_a[i]) < nw_of(i));
    if (p_we[i]) begin
      if (inr) begin mm[i][p_a[i]] = p_d[i]; mk[i][p_a[i]] = 1'b1; end
      res_d[i] = 32'd0; res_k[i] = 1'b1;
    end else if (inr) begin
      res_d[i] = mm[i][p_a[i]]; res_k[i] = mk[i][p_a[i]];
    end else begin
      res_d[i] = 32'd0; res_k[i] = 1'b1;
    end
    res_e[i] = !inr;
    resp[i]  = 1'b1;
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        for (int i = 0; i < 3; i++) begin
          if (busy[i] && resp[i]) begin
            if (rs_r[i]) begin busy[i] = 1'b0; resp[i] = 1'b0; end
          end else if (busy[i]) begin
            wl[i]--;
            if (wl[i] == 0) finish_req(i);
          end else if (rok[i] && rq_v[i]) begin
            busy[i] = 1'b1;
            p_we[i] = rq_we[i]; p_a[i] = rq_a[i]; p_d[i] = rq_d[i];
            wl[i] = lat_of(i);
            if (wl[i] == 0) finish_req(i);
          end
          rok[i] = 1'b1;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("d%0d_req_ready", i), 32'(req_ready_o[i]), 32'(rok[i] && !busy[i]));
      chk($sformatf("d%0d_rsp_valid", i), 32'(rsp_valid_o[i]), 32'(busy[i] && resp[i]));
      chk($sformatf("d%0d_rsp_err", i), 32'(rsp_err_o[i]), 32'(res_e[i]));
      if (res_k[i]) chk($sformatf("d%0d_rsp_rdata", i), rsp_rdata_o[i], res_d[i]);
    end
  end

  // One request/response; stall = cycles rsp_ready is held low once rsp_valid is seen.
  task automatic xact(input int i, input bit we, input logic [6:0] a, input logic [31:0] d,
                      input int stall, input logic [31:0] hold_exp,
                      output logic [31:0] rd, output logic er, output int lat);
    int n;
    n = 0; rd = 32'd0; er = 1'b0; lat = -1;
    @(posedge clk); #1;
    rq_v[i] = 1'b1; rq_we[i] = we; rq_a[i] = a; rq_d[i] = d; rs_r[i] = (stall == 0);
    @(negedge clk);
    while (!req_ready_o[i] && n < 40) begin @(negedge clk); n++; end
    if (!req_ready_o[i]) begin
      chk("accept_timeout", 32'd0, 32'd1);
      rq_v[i] = 1'b0; rs_r[i] = 1'b1;
      return;
    end
    @(posedge clk); #1;
    rq_v[i] = 1'b0; rq_we[i] = !we; rq_a[i] = ~a; rq_d[i] = ~d;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rsp_valid_o[i] && lat < 40);
    if (!rsp_valid_o[i]) begin
      chk("rsp_timeout", 32'd0, 32'd1);
      rs_r[i] = 1'b1;
      return;
    end
    for (int s = 0; s < stall; s++) begin
      chk("stall_rsp_valid", 32'(rsp_valid_o[i]), 32'd1);
      chk("stall_rdata", rsp_rdata_o[i], hold_exp);
      chk("stall_req_ready", 32'(req_ready_o[i]), 32'd0);
      @(negedge clk);
    end
    rd = rsp_rdata_o[i]; er = rsp_err_o[i];
    rs_r[i] = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=not finished required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat, k;
    bit          acc;
    int          acc_c[$];
    logic [31:0] got[$];

    for (int i = 0; i < 3; i++) begin
      rq_v[i] = 1'b0; rq_we[i] = 1'b0; rq_a[i] = 7'd0; rq_d[i] = 32'd0; rs_r[i] = 1'b1;
    end
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_req_ready", 32'(req_ready_o[0]), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid_o[0]), 32'd0);
    rst_n = 1'b1;
    #1 chk("release_pre_edge_ready", 32'(req_ready_o[0]), 32'd0);
    @(posedge clk); #1 chk("release_first_edge_ready", 32'(req_ready_o[0]), 32'd1);

    xact(0, 1'b1, 7'd5, 32'hDEADBEEF, 0, 32'd0, rd, er, lat);
    chk("wr5_latency", 32'(lat), WEN ? 32'd3 : 32'd1);
    chk("wr5_rdata", rd, 32'd0);
    chk("wr5_err", 32'(er), 32'd0);
    xact(0, 1'b0, 7'd5, 32'd0, 0, 32'd0, rd, er, lat);
    chk("rd5_rdata", rd, 32'hDEADBEEF);

    xact(0, 1'b1, 7'd3, 32'h12345678, 0, 32'd0, rd, er, lat);
    xact(0, 1'b0, 7'd3, 32'd0, 4, 32'h12345678, rd, er, lat);
    chk("rd3_stalled_rdata", rd, 32'h12345678);

    xact(0, 1'b1, 7'd7, 32'h00000777, 0, 32'd0, rd, er, lat);
    xact(0, 1'b1, 7'd36, 32'hA5A50036, 0, 32'd0, rd, er, lat);
    xact(0, 1'b1, 7'd100, 32'h0BAD0BAD, 0, 32'd0, rd, er, lat);
    chk("wr100_err", 32'(er), 32'd1);
    chk("wr100_rdata", rd, 32'd0);
    xact(0, 1'b0, 7'd36, 32'd0, 0, 32'd0, rd, er, lat);
    chk("rd36_unchanged", rd, 32'hA5A50036);
    chk("rd36_err", 32'(er), 32'd0);

    // Reset lands in the cycle after accepting a write to addr 7.
    @(posedge clk); #1;
    rq_v[0] = 1'b1; rq_we[0] = 1'b1; rq_a[0] = 7'd7; rq_d[0] = 32'hFFFFFFFF;
    @(negedge clk) chk("wr7_accept_ready", 32'(req_ready_o[0]), 32'd1);
    @(posedge clk); #1;
    rq_v[0] = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_rst_rsp_valid", 32'(rsp_valid_o[0]), 32'd0);
    chk("async_rst_req_ready", 32'(req_ready_o[0]), 32'd0);
    chk("async_rst_rdata", rsp_rdata_o[0], 32'd0);
    chk("async_rst_err", 32'(rsp_err_o[0]), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst2_pre_edge_ready", 32'(req_ready_o[0]), 32'd0);
    @(posedge clk); #1 chk("rst2_first_edge_ready", 32'(req_ready_o[0]), 32'd1);
    xact(0, 1'b0, 7'd7, 32'd0, 0, 32'd0, rd, er, lat);
    chk("rd7_after_reset", rd, WEN ? 32'h00000777 : 32'hFFFFFFFF);

    xact(2, 1'b1, 7'd0, 32'h0000CAFE, 0, 32'd0, rd, er, lat);
    xact(2, 1'b0, 7'd0, 32'd0, 0, 32'd0, rd, er, lat);
    chk("w5_rd0_latency", 32'(lat), WEN ? 32'd6 : 32'd1);
    chk("w5_rd0_rdata", rd, 32'h0000CAFE);

    for (int j = 0; j < 4; j++)
      xact(1, 1'b1, 7'(10 + j), 32'hC0DE000A + 32'(j), 0, 32'd0, rd, er, lat);
    @(posedge clk); #1;
    rq_we[1] = 1'b0; rq_a[1] = 7'd10; rq_v[1] = 1'b1; k = 0;
    for (int c = 0; c < 60 && got.size() < 4; c++) begin
      @(negedge clk);
      if (rsp_valid_o[1]) got.push_back(rsp_rdata_o[1]);
      acc = rq_v[1] && req_ready_o[1];
      if (acc) acc_c.push_back(c);
      @(posedge clk); #1;
      if (acc) begin
        k++;
        if (k == 4) rq_v[1] = 1'b0;
        else rq_a[1] = 7'(10 + k);
      end
    end
    rq_v[1] = 1'b0;
    chk("stream_accepts", 32'(acc_c.size()), 32'd4);
    for (int j = 1; j < acc_c.size(); j++)
      chk("stream_accept_spacing", 32'(acc_c[j] - acc_c[j-1]), 32'd2);
    chk("stream_responses", 32'(got.size()), 32'd4);
    for (int j = 0; j < got.size(); j++)
      chk($sformatf("stream_rdata_%0d", j), got[j], 32'hC0DE000A + 32'(j));

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
